// File: rtl/tetris_pkg.sv
// ============================================================================
// tetris_pkg : shared board types, FSM states and score lookup (honours BOARD_CLEAR_WEIGHTED_SCORE_EN)
// Rev 1.0
// ============================================================================
`default_nettype none

package tetris_pkg;

  localparam int BOARD_W_DEF = 12;
  localparam int BOARD_H_DEF = 19;

  typedef logic [15:0] row_t;
  typedef logic [5:0]  coord_x_t;
  typedef logic [6:0]  coord_y_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOCK  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_ZERO  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [15:0] points(input logic [2:0] lines);
`ifdef BOARD_CLEAR_WEIGHTED_SCORE_EN
    case (lines)
      3'd0:    points = 16'd0;
      3'd1:    points = 16'd100;
      3'd2:    points = 16'd300;
      3'd3:    points = 16'd500;
      default: points = 16'd800;
    endcase
`else
    points = {13'd0, lines};
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/board_clear_ctrl_if.sv
// ============================================================================
// board_clear_ctrl_if : lock handshake, row read port and status of the playfield controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface board_clear_ctrl_if;
  import tetris_pkg::*;

  logic        lock_valid;
  logic        lock_ready;
  logic [23:0] lock_x;
  logic [27:0] lock_y;
  logic [6:0]  rd_row;
  row_t        rd_data;
  logic        busy;
  logic        clear_done;
  logic [2:0]  lines_cleared;
  logic [15:0] score;
  logic        game_over;

  modport master (
    output lock_valid, lock_x, lock_y, rd_row,
    input  lock_ready, rd_data, busy, clear_done, lines_cleared, score, game_over
  );

  modport slave (
    input  lock_valid, lock_x, lock_y, rd_row,
    output lock_ready, rd_data, busy, clear_done, lines_cleared, score, game_over
  );

endinterface

`default_nettype wire

// File: rtl/board_clear_ctrl.sv
// ============================================================================
// board_clear_ctrl : playfield owner - writes locked pieces, clears full rows, scores
// Macro BOARD_CLEAR_WEIGHTED_SCORE_EN selects weighted points.  Rev 1.0
// ============================================================================
`default_nettype none

module board_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF
) (
  input  logic               frame_clk,
  input  logic               Reset,
  board_clear_ctrl_if.slave  bus
);

  localparam row_t ROW_MASK = row_t'((32'd1 << BOARD_W) - 32'd1);

  state_t      state_q, state_d;
  row_t        board_q [BOARD_H];
  row_t        board_d [BOARD_H];
  coord_y_t    r_q, r_d;
  coord_y_t    k_q, k_d;
  logic [2:0]  lines_q, lines_d;
  logic [2:0]  lines_cleared_q, lines_cleared_d;
  logic [15:0] score_q, score_d;
  logic        game_over_q, game_over_d;
  logic [23:0] lock_x_q, lock_x_d;
  logic [27:0] lock_y_q, lock_y_d;

  row_t        scan_row;
  row_t        rd_data_w;
  logic        row_full;
  logic [16:0] score_sum;

  always_comb begin
    scan_row  = '0;
    rd_data_w = '0;
    for (int i = 0; i < BOARD_H; i++) begin
      if (r_q == coord_y_t'(i))        scan_row  = board_q[i];
      if (bus.rd_row == coord_y_t'(i)) rd_data_w = board_q[i];
    end
  end

  assign row_full  = ((scan_row & ROW_MASK) == ROW_MASK);
  assign score_sum = {1'b0, score_q} + {1'b0, points(lines_q)};

  always_comb begin
    state_d         = state_q;
    board_d         = board_q;
    r_d             = r_q;
    k_d             = k_q;
    lines_d         = lines_q;
    lines_cleared_d = lines_cleared_q;
    score_d         = score_q;
    game_over_d     = game_over_q;
    lock_x_d        = lock_x_q;
    lock_y_d        = lock_y_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.lock_valid && !game_over_q) begin
          lock_x_d = bus.lock_x;
          lock_y_d = bus.lock_y;
          state_d  = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // Off-board cells are dropped; duplicates simply set the same bit twice.
        for (int n = 0; n < 4; n++) begin
          if ((lock_x_q[6*n +: 6] < coord_x_t'(BOARD_W)) &&
              ({1'b0, lock_y_q[7*n +: 7]} < 8'(BOARD_H))) begin
            for (int i = 0; i < BOARD_H; i++) begin
              if (lock_y_q[7*n +: 7] == coord_y_t'(i))
                board_d[i][lock_x_q[6*n +: 4]] = 1'b1;
            end
          end
        end
        r_d     = coord_y_t'(BOARD_H - 1);
        lines_d = 3'd0;
        state_d = ST_SCAN;
      end

      ST_SCAN: begin
        if (row_full) begin
          lines_d = (lines_q == 3'd7) ? 3'd7 : lines_q + 3'd1;
          k_d     = r_q;
          state_d = (r_q == 7'd0) ? ST_ZERO : ST_SHIFT;
        end else if (r_q == 7'd0) begin
          state_d = ST_DONE;
        end else begin
          r_d = r_q - 7'd1;
        end
      end

      ST_SHIFT: begin
        for (int i = 1; i < BOARD_H; i++) begin
          if (k_q == coord_y_t'(i)) board_d[i] = board_q[i-1];
        end
        k_d = k_q - 7'd1;
        if (k_q == 7'd1) state_d = ST_ZERO;
      end

      // r is left alone so the row that dropped into it gets re-tested.
      ST_ZERO: begin
        board_d[0] = '0;
        state_d    = ST_SCAN;
      end

      ST_DONE: begin
        lines_cleared_d = lines_q;
        score_d         = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        if (board_q[0] != '0) game_over_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= ST_IDLE;
      for (int i = 0; i < BOARD_H; i++) board_q[i] <= '0;
      r_q             <= '0;
      k_q             <= '0;
      lines_q         <= '0;
      lines_cleared_q <= '0;
      score_q         <= '0;
      game_over_q     <= 1'b0;
      lock_x_q        <= '0;
      lock_y_q        <= '0;
    end else begin
      state_q         <= state_d;
      board_q         <= board_d;
      r_q             <= r_d;
      k_q             <= k_d;
      lines_q         <= lines_d;
      lines_cleared_q <= lines_cleared_d;
      score_q         <= score_d;
      game_over_q     <= game_over_d;
      lock_x_q        <= lock_x_d;
      lock_y_q        <= lock_y_d;
    end
  end

  assign bus.lock_ready    = (state_q == ST_IDLE) && !game_over_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.clear_done    = (state_q == ST_DONE);
  // The fresh count is visible during the done pulse, then held.
  assign bus.lines_cleared = (state_q == ST_DONE) ? lines_q : lines_cleared_q;
  assign bus.score         = score_q;
  assign bus.game_over     = game_over_q;
  assign bus.rd_data       = rd_data_w;

endmodule

`default_nettype wire
